// File: rtl/rom_register_file.sv
// rom_register_file: 32 x DATA_W register file bulk-loaded from a registered ROM, then written by the datapath.
// Build macro REG_ZERO_HARDWIRED_EN makes register 0 a constant zero.
module rom_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic [ADDR_W-1:0]                  rom_addr,
  input  logic [DATA_W-1:0]                  rom_data,
  input  logic                               wr_en,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic                               busy,
  output logic                               done,
  output logic [(1 << ADDR_W)*DATA_W-1:0]    reg_bus
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic {IDLE, LOAD} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_next;
  logic [ADDR_W:0]   cnt_prev;
  logic              done_next;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      done  <= done_next;
    end
  end

  // The load runs one cycle past the last address so the final registered ROM word lands.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          cnt_next   = '0;
        end
      end
      LOAD: begin
        if (cnt == LAST_CNT) begin
          state_next = IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
    endcase
  end

  assign busy     = (state == LOAD);
  assign rom_addr = busy ? cnt[ADDR_W-1:0] : '0;

  // ROM data lags its address by one cycle, hence register cnt-1 is the target.
  always_comb begin
    cnt_prev = cnt - ONE;
    we       = 1'b0;
    waddr    = wr_addr;
    wdata    = wr_data;
    if (state == IDLE) begin
      we = wr_en;
    end else if (cnt != '0) begin
      we    = 1'b1;
      waddr = cnt_prev[ADDR_W-1:0];
      wdata = rom_data;
    end
`ifdef REG_ZERO_HARDWIRED_EN
    if (waddr == '0) begin
      we = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_bus
`ifdef REG_ZERO_HARDWIRED_EN
    if (k == 0) begin : g_zero
      assign reg_bus[DATA_W-1:0] = '0;
    end else begin : g_reg
      assign reg_bus[k*DATA_W +: DATA_W] = regs[k];
    end
`else
    assign reg_bus[k*DATA_W +: DATA_W] = regs[k];
`endif
  end

endmodule

// File: tb/tb_rom_register_file.sv
// Directed self-checking bench for rom_register_file; follows REG_ZERO_HARDWIRED_EN if defined.
module tb_rom_register_file;

  logic          clk;
  logic          rst;
  logic          start;
  logic [4:0]    rom_addr;
  logic [31:0]   rom_data;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          done;
  logic [1023:0] reg_bus;

  int checks;
  int errors;
  int busy_cnt;
  int done_cnt;
  logic [31:0] exp_regs [32];

  rom_register_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .reg_bus  (reg_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered ROM: word = 0xA500_0000 + address, one cycle latency
  always @(posedge clk) rom_data <= 32'hA500_0000 + 32'(rom_addr);

  // counts busy / done cycles as they end (values seen before the edge updates)
  always @(posedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic set_loaded_model();
    for (int k = 0; k < 32; k++) exp_regs[k] = 32'hA500_0000 + k;
`ifdef REG_ZERO_HARDWIRED_EN
    exp_regs[0] = 32'h0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'($urandom_range(0, 1));
    wr_en = 1'($urandom_range(0, 1));
    wr_addr = 5'($urandom_range(0, 31));
    wr_data = $urandom;
    @(negedge clk);
    start = 1'($urandom_range(0, 1));
    wr_en = 1'($urandom_range(0, 1));
    wr_addr = 5'($urandom_range(0, 31));
    wr_data = $urandom;
    @(negedge clk);
    checks++;
    if (reg_bus !== '0) begin errors++; $display("[TB] FAIL reset_bus: got %h expected 0", reg_bus); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (rom_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
    rst = 1'b0;
    start = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int k = 0; k < 32; k++) exp_regs[k] = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_full_load();
    logic        exp_busy;
    logic        exp_done;
    logic [4:0]  exp_addr;
    start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      exp_busy = (i >= 1 && i <= 33);
      exp_done = (i == 34);
      exp_addr = (i >= 1 && i <= 32) ? 5'(i - 1) : 5'd0;
      checks++;
      if (busy !== exp_busy) begin errors++; $display("[TB] FAIL load_busy cycle %0d: got %b expected %b", i, busy, exp_busy); end
      checks++;
      if (done !== exp_done) begin errors++; $display("[TB] FAIL load_done cycle %0d: got %b expected %b", i, done, exp_done); end
      checks++;
      if (rom_addr !== exp_addr) begin errors++; $display("[TB] FAIL load_rom_addr cycle %0d: got %0d expected %0d", i, rom_addr, exp_addr); end
    end
    set_loaded_model();
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (reg_bus[k*32 +: 32] !== exp_regs[k]) begin errors++; $display("[TB] FAIL load_reg%0d: got %h expected %h", k, reg_bus[k*32 +: 32], exp_regs[k]); end
    end
  endtask

  task automatic test_idle_write();
    wr_en = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    wr_en = 1'b0;
    exp_regs[7] = 32'hDEAD_BEEF;
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (reg_bus[k*32 +: 32] !== exp_regs[k]) begin errors++; $display("[TB] FAIL write7_reg%0d: got %h expected %h", k, reg_bus[k*32 +: 32], exp_regs[k]); end
    end
    wr_en = 1'b1;
    wr_addr = 5'd0;
    @(negedge clk);
    wr_en = 1'b0;
`ifdef REG_ZERO_HARDWIRED_EN
    exp_regs[0] = 32'h0;
`else
    exp_regs[0] = 32'hDEAD_BEEF;
`endif
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (reg_bus[k*32 +: 32] !== exp_regs[k]) begin errors++; $display("[TB] FAIL write0_reg%0d: got %h expected %h", k, reg_bus[k*32 +: 32], exp_regs[k]); end
    end
  endtask

  task automatic test_ignored_inputs();
    busy_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ign_busy_mid: got %b expected 1", busy); end
    wr_en = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h1234_5678;
    start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (busy_cnt !== 33) begin errors++; $display("[TB] FAIL ign_busy_len: got %0d expected 33", busy_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("[TB] FAIL ign_done_pulses: got %0d expected 1", done_cnt); end
    set_loaded_model();
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (reg_bus[k*32 +: 32] !== exp_regs[k]) begin errors++; $display("[TB] FAIL ign_reg%0d: got %h expected %h", k, reg_bus[k*32 +: 32], exp_regs[k]); end
    end
  endtask

  task automatic test_reset_midload();
    busy_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++;
    if (rom_addr !== 5'd0) begin errors++; $display("[TB] FAIL midrst_rom_addr: got %0d expected 0", rom_addr); end
    checks++;
    if (reg_bus !== '0) begin errors++; $display("[TB] FAIL midrst_bus: got %h expected 0", reg_bus); end
    repeat (30) @(negedge clk);
    checks++;
    if (done_cnt !== 0) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d expected 0", done_cnt); end
    checks++;
    if (reg_bus !== '0) begin errors++; $display("[TB] FAIL midrst_bus_later: got %h expected 0", reg_bus); end
    busy_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (busy_cnt !== 33) begin errors++; $display("[TB] FAIL reload_busy_len: got %0d expected 33", busy_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("[TB] FAIL reload_done_pulses: got %0d expected 1", done_cnt); end
    set_loaded_model();
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (reg_bus[k*32 +: 32] !== exp_regs[k]) begin errors++; $display("[TB] FAIL reload_reg%0d: got %h expected %h", k, reg_bus[k*32 +: 32], exp_regs[k]); end
    end
  endtask

  task automatic test_simultaneous();
    busy_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    wr_en = 1'b1;
    wr_addr = 5'd31;
    wr_data = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL simul_busy: got %b expected 1", busy); end
    checks++;
    if (reg_bus[31*32 +: 32] !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL simul_reg31_early: got %h expected ffffffff", reg_bus[31*32 +: 32]); end
    repeat (20) @(negedge clk);
    checks++;
    if (reg_bus[31*32 +: 32] !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL simul_reg31_mid: got %h expected ffffffff", reg_bus[31*32 +: 32]); end
    repeat (20) @(negedge clk);
    checks++;
    if (reg_bus[31*32 +: 32] !== 32'hA500_001F) begin errors++; $display("[TB] FAIL simul_reg31_final: got %h expected a500001f", reg_bus[31*32 +: 32]); end
    checks++;
    if (busy_cnt !== 33) begin errors++; $display("[TB] FAIL simul_busy_len: got %0d expected 33", busy_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("[TB] FAIL simul_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    busy_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (33) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done_cycle: got %b expected 1", done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_in_done: got %b expected 0", busy); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_drop: got %b expected 0", done); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_restart_busy: got %b expected 1", busy); end
    checks++;
    if (rom_addr !== 5'd0) begin errors++; $display("[TB] FAIL b2b_rom_addr: got %0d expected 0", rom_addr); end
    repeat (40) @(negedge clk);
    checks++;
    if (busy_cnt !== 66) begin errors++; $display("[TB] FAIL b2b_busy_total: got %0d expected 66", busy_cnt); end
    checks++;
    if (done_cnt !== 2) begin errors++; $display("[TB] FAIL b2b_done_total: got %0d expected 2", done_cnt); end
    set_loaded_model();
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (reg_bus[k*32 +: 32] !== exp_regs[k]) begin errors++; $display("[TB] FAIL b2b_reg%0d: got %h expected %h", k, reg_bus[k*32 +: 32], exp_regs[k]); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    busy_cnt = 0;
    done_cnt = 0;
    rom_data = '0;
    test_reset();
    test_full_load();
    test_idle_write();
    test_ignored_inputs();
    test_reset_midload();
    test_simultaneous();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_register_file.md
# rom_register_file

32-entry × 32-bit register file that produces the flattened register bus consumed by the 32-to-1 read-select mux stage. After a start request it bulk-initialises every register from an external synchronous ROM. It then accepts single-register writes from the datapath. It is the storage stage directly upstream of the read mux: the mux selects one word from this block's output bus.

## Interface
Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register/ROM address width. The register count is fixed at 2^ADDR_W = 32.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a full ROM-to-register load. Sampled only in IDLE.
- rom_addr  output  ADDR_W  ROM read address.
- rom_data  input  DATA_W  ROM read data. Valid one cycle after rom_addr is presented (registered ROM).
- wr_en  input  1  datapath write strobe. Honoured only in IDLE.
- wr_addr  input  ADDR_W  target register for the datapath write.
- wr_data  input  DATA_W  data for the datapath write.
- busy  output  1  high while a load is in progress.
- done  output  1  one-cycle pulse when a load completes.
- reg_bus  output  32*DATA_W  all registers, flattened. Register k occupies bits [k*DATA_W+DATA_W-1 : k*DATA_W]. Driven directly from flops and feeds the read mux inputs in0..in31.

## Operation
- The state machine has two states, IDLE and LOAD, plus a 6-bit load counter cnt.
- Reset (rst=1 at an edge), which takes priority over everything else:
  - every register clears to 0;
  - state goes to IDLE and cnt goes to 0;
  - rom_addr=0, busy=0, done=0.
- IDLE:
  - wr_en=1 writes wr_data into register wr_addr at the edge.
  - start=1 moves the block to LOAD with cnt=0.
  - If start and wr_en are both asserted in the same cycle, the write is performed and the load also begins. The load later overwrites that register.
- LOAD:
  - rom_addr = cnt[4:0].
  - At each edge with cnt ≥ 1, register cnt-1 <= rom_data.
  - cnt increments every cycle.
  - When cnt = 32, the final write (register 31) occurs at that edge and the block returns to IDLE. done is 1 for the following single cycle.
  - In the cnt = 32 cycle, rom_addr = 0; that ROM read is ignored.
- wr_en and start are ignored throughout LOAD. There is no queuing and no error flag.
- done deasserts after one cycle, even if start is asserted again immediately.
- A reset asserted mid-load aborts the load. All registers are zero afterwards, including those already loaded, and no done pulse is produced.

## Timing
- start is sampled at edge T0. busy=1 and rom_addr=0 from T0+1.
- rom_addr steps through 0..31 in cycles T0+1..T0+32. Register k is written at edge T0+k+2.
- busy is high for exactly 33 cycles (T0+1..T0+33). done=1 in cycle T0+34 only, and busy=0 from T0+34.
- A datapath write at edge T is visible on reg_bus from cycle T+1. There is no write-to-read bypass.
- A new start is accepted in the done cycle, since the block is already in IDLE.

## Configuration
- REG_ZERO_HARDWIRED_EN:
  - Defined: register 0 is constant 0. Datapath writes to address 0 are discarded, the ROM word for address 0 is discarded during load, and reg_bus bits [DATA_W-1:0] are tied to 0.
  - Undefined: register 0 behaves like every other register.
  - Load timing, busy and done are identical in both builds.

## Test plan
- Reset: hold rst 2 cycles with random start, wr_en and wr_data. Required response: reg_bus all 0, busy=0, done=0, rom_addr=0.
- Full load: the ROM model returns 0xA500_0000+addr with 1-cycle latency; pulse start. Required response:
  - busy high for exactly 33 cycles, followed by a single done pulse;
  - register k = 0xA500_0000+k for all k;
  - with REG_ZERO_HARDWIRED_EN defined, register 0 = 0 instead.
- Idle write: wr_en, wr_addr=7, wr_data=0xDEAD_BEEF. Required response: register 7 = 0xDEAD_BEEF from the next cycle, all other registers unchanged. A repeat with wr_addr=0 shows 0 when REG_ZERO_HARDWIRED_EN is defined, 0xDEAD_BEEF when it is not.
- Ignored inputs during load: assert wr_en (addr 3, 0x1234_5678) and start during LOAD cycle 5. Required response: register 3 ends at the ROM value 0xA500_0003, the load length stays 33 cycles, and there is only one done pulse.
- Reset mid-load: assert rst at LOAD cycle 10. Required response: all registers 0, busy=0 next cycle, no done. A following start performs a clean full load.
- Simultaneous start and wr_en in IDLE (addr 31, 0xFFFF_FFFF). Required response: register 31 = 0xFFFF_FFFF during the load, then 0xA500_001F after it completes.
